// File: rtl/pmod_ssd_capture_if.sv
// PmodSSD capture bus: raw display pins in, decoded value and status out.
// master = pin driver / consumer side, slave = the capture block.
interface pmod_ssd_capture_if;
  logic [7:0] i_ssd_pmod;
  logic [7:0] o_value;
  logic       o_valid;
  logic       o_seg_err;
  logic       o_stale;

  modport master (output i_ssd_pmod, input o_value, o_valid, o_seg_err, o_stale);
  modport slave  (input i_ssd_pmod, output o_value, o_valid, o_seg_err, o_stale);
endinterface

// File: rtl/pmod_ssd_capture.sv
// Loopback monitor for a multiplexed PmodSSD: demuxes, debounces and decodes two digits.
// Optional macro SSD_CAPTURE_CHANGE_ONLY_EN: o_valid only pulses when the published pair changes.
//
// state       | meaning
// ST_WAIT     | waiting for a stable segment pattern on the current digit
// ST_CAPTURED | pattern for the current digit taken; watching for a change
module pmod_ssd_capture #(
  parameter int par_stable_cycles  = 16,
  parameter int par_timeout_cycles = 600000
) (
  input  logic             i_clk_20mhz,
  input  logic             i_rst_20mhz,
  pmod_ssd_capture_if.slave bus
);
  localparam int FW = $clog2(par_stable_cycles);
  localparam int TW = $clog2(par_timeout_cycles);
  localparam logic [FW-1:0] FILT_MAX = FW'(par_stable_cycles - 1);
  localparam logic [FW-1:0] FILT_PRE = FW'(par_stable_cycles - 2);
  localparam logic [TW-1:0] TO_MAX   = TW'(par_timeout_cycles - 1);
  localparam logic [TW-1:0] TO_PRE   = TW'(par_timeout_cycles - 2);

  typedef enum logic {ST_WAIT, ST_CAPTURED} state_t;

  state_t        state_q, state_d;
  logic [7:0]    meta_q, sync_q;
  logic          sel_q;
  logic [6:0]    seg_prev_q;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    nib0_q, nib0_d, nib1_q, nib1_d;
  logic          flag0_q, flag0_d, flag1_q, flag1_d;
  logic          pub_pend_q, pub_pend_d;
  logic [7:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          seg_err_q, seg_err_d;
  logic          stale_q, stale_d;
  logic          sel_edge, seg_eq, stable, capture, to_hit;
  logic [4:0]    dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;  7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;  7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;  7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;  7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;  7'h67: decode = 5'h19;
      7'h77: decode = 5'h1A;  7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;  7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;  7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      meta_q     <= '0;
      sync_q     <= '0;
      sel_q      <= 1'b0;
      seg_prev_q <= '0;
      filt_q     <= '0;
      to_q       <= '0;
      state_q    <= ST_WAIT;
      nib0_q     <= '0;
      nib1_q     <= '0;
      flag0_q    <= 1'b0;
      flag1_q    <= 1'b0;
      pub_pend_q <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      meta_q     <= bus.i_ssd_pmod;
      sync_q     <= meta_q;
      sel_q      <= sync_q[7];
      seg_prev_q <= sync_q[6:0];
      filt_q     <= filt_d;
      to_q       <= to_d;
      state_q    <= state_d;
      nib0_q     <= nib0_d;
      nib1_q     <= nib1_d;
      flag0_q    <= flag0_d;
      flag1_q    <= flag1_d;
      pub_pend_q <= pub_pend_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      seg_err_q  <= seg_err_d;
      stale_q    <= stale_d;
    end
  end

  always_comb begin
    sel_edge   = sync_q[7] ^ sel_q;
    seg_eq     = (sync_q[6:0] == seg_prev_q);
    // Stable is asserted on the cycle the counter lands on its top value, and held while saturated
    stable     = seg_eq && ((filt_q == FILT_PRE) || (filt_q == FILT_MAX));
    to_hit     = !sel_edge && (to_q == TO_PRE);
    dec        = decode(sync_q[6:0]);

    filt_d     = filt_q;
    to_d       = to_q;
    stale_d    = stale_q;
    state_d    = state_q;
    capture    = 1'b0;
    nib0_d     = nib0_q;
    nib1_d     = nib1_q;
    flag0_d    = flag0_q;
    flag1_d    = flag1_q;
    pub_pend_d = 1'b0;
    value_d    = value_q;
    valid_d    = 1'b0;
    seg_err_d  = 1'b0;

    if (sel_edge || !seg_eq) filt_d = '0;
    else if (filt_q != FILT_MAX) filt_d = filt_q + 1'b1;

    if (sel_edge) begin
      to_d    = '0;
      stale_d = 1'b0;
    end else begin
      if (to_q != TO_MAX) to_d = to_q + 1'b1;
      if (to_hit) stale_d = 1'b1;
    end

    if (sel_edge) state_d = ST_WAIT;
    else begin
      case (state_q)
        ST_WAIT: if (stable) begin
          capture = 1'b1;
          state_d = ST_CAPTURED;
        end
        ST_CAPTURED: if (!seg_eq) state_d = ST_WAIT;
        default: state_d = ST_WAIT;
      endcase
    end

    if (pub_pend_q) begin
      value_d = {nib1_q, nib0_q};
`ifdef SSD_CAPTURE_CHANGE_ONLY_EN
      valid_d = ({nib1_q, nib0_q} != value_q);
`else
      valid_d = 1'b1;
`endif
      flag0_d = 1'b0;
      flag1_d = 1'b0;
    end

    if (capture) begin
      seg_err_d = !dec[4] && (sync_q[6:0] != 7'h00);
      if (sync_q[7]) begin
        flag1_d = dec[4];
        if (dec[4]) nib1_d = dec[3:0];
      end else begin
        flag0_d = dec[4];
        if (dec[4]) nib0_d = dec[3:0];
      end
      pub_pend_d = dec[4] && !to_hit && (sync_q[7] ? flag0_q : flag1_q);
    end

    if (to_hit) begin
      flag0_d = 1'b0;
      flag1_d = 1'b0;
    end
  end

  assign bus.o_value   = value_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_seg_err = seg_err_q;
  assign bus.o_stale   = stale_q;
endmodule

// File: doc/pmod_ssd_capture.md
Name: pmod_ssd_capture

Overview:
- Receive-side counterpart of the PmodSSD output path.
- Samples the 8-bit multiplexed PmodSSD bus: segments [6:0] plus digit select [7].
- Demultiplexes, debounces and decodes the two 7-segment digits back into an 8-bit hex value.
- Used as a loopback/self-check monitor: a second Pmod port is wired to the display port, and the captured value is compared with the value being displayed.

Parameters:
- par_stable_cycles, 16: consecutive identical synchronized samples required before a segment pattern is accepted (>=2).
- par_timeout_cycles, 600000: clocks without a select edge before the bus is declared stale. This is 3x the 100 Hz phase length at 20 MHz.

Ports:
- i_clk_20mhz  in  1  system clock, 20 MHz.
- i_rst_20mhz  in  1  reset, asynchronous, active-high.
- i_ssd_pmod  in  8  raw pins; [6:0] segments, bit 0 = segment A, active-high; [7] select, 0 = digit0 (right), 1 = digit1 (left).
- o_value  out  8  last published pair, {digit1, digit0}.
- o_valid  out  1  one-cycle pulse when o_value is published.
- o_seg_err  out  1  one-cycle pulse when a stable, non-blank, non-hex pattern is accepted.
- o_stale  out  1  level; select has not toggled for par_timeout_cycles.

Behaviour:
- Reset (async assert, sync release): o_value=8'h00, o_valid=0, o_seg_err=0, o_stale=0. Filter counter, timeout counter, capture flags and FSM state are all cleared. FSM enters ST_WAIT.
- Synchronizer: two-flop synchronizer on all 8 input bits. All logic below uses the synchronized word s_sync.
- Select edge: a change of s_sync[7] versus its registered copy.
  - Restarts the filter counter and the timeout counter.
  - Forces the FSM to ST_WAIT.
  - Clears o_stale.
- Stability filter: compare s_sync[6:0] with the previous synchronized sample.
  - Equal: the counter increments, saturating at par_stable_cycles-1.
  - Different: the counter resets to 0.
  - "Stable" = counter reached par_stable_cycles-1 with the sample still equal.
- FSM:
  - ST_WAIT, stable: decode the pattern. Next state is ST_CAPTURED.
  - ST_CAPTURED, segment change with no select edge: return to ST_WAIT. This allows recapture, and the newer stable value overwrites the older one.
  - ST_CAPTURED, select edge: go to ST_WAIT.
- Decode table (pattern -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
  - Valid hex: store the nibble in the slot given by s_sync[7] and set that slot's flag.
  - 7'h00 (blank or driver reset): clear that slot's flag. No error.
  - Any other pattern: clear that slot's flag and pulse o_seg_err for one cycle.
- Publish:
  - Trigger: the cycle after a capture sets a flag while the other slot's flag is already set.
  - Action: o_value <= {slot1, slot0}, o_valid pulses for one cycle, and both flags clear.
  - Result: one publish per fresh digit pair, in either slot order.
- Latency: the last pin change of the second digit reaches o_valid after 2 (synchronizer) + par_stable_cycles + 1 clocks.
- Timeout: the counter increments every clock while no select edge occurs.
  - On reaching par_timeout_cycles-1: o_stale=1, both flags clear, and the counter holds.
  - o_stale stays high until the next select edge. Captures are still allowed during stale.
- Simultaneous events:
  - Select edge takes priority over a stable event in the same cycle. The pending capture is discarded.
  - Timeout and a capture in the same cycle: the timeout clear wins.
- Counter widths: $clog2 of the respective parameter. No wrap-around; both counters saturate.

Optional Feature:
- Macro SSD_CAPTURE_CHANGE_ONLY_EN.
- Defined: on a publish, o_valid pulses only if the new pair differs from the current o_value. o_value still updates, and flags still clear.
- Undefined: o_valid pulses on every completed pair.

Test Plan:
- Alternate select every 1000 clocks; sel=0 with 4F, sel=1 with 66 -> o_value=8'h43, exactly one o_valid per sel0+sel1 pair, first pulse 2+16+1 clocks after the sel=1 data settles.
- During the sel=0 phase holding 3F, a 5-cycle glitch to 06 -> glitch never captured, o_value low nibble = 0.
- sel=1 pattern 7'h01 held 1000 clocks -> one o_seg_err pulse, no o_valid for that pair, o_value unchanged.
- Select frozen 600000 clocks -> o_stale=1 at clock 600000. Resume toggling -> o_stale=0 on the first edge, o_valid after the next full pair.
- Assert i_rst_20mhz asynchronously mid-filter -> all outputs 0 without a clock edge. After release, no o_valid until two new captures.
- Same pair 8'h5A sent twice -> two o_valid pulses without SSD_CAPTURE_CHANGE_ONLY_EN, one with it.
